// File: rtl/sample_sequencer_pkg.sv
// Shared defaults and FSM encoding for the sample sequencer.
package sample_sequencer_pkg;
  localparam int NUM_CHANNELS_DEFAULT = 14;
  localparam int SAMPLE_BITS_DEFAULT  = 8;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    SETTLE,
    CAPTURE,
    PRESENT
  } state_t;
endpackage

// File: rtl/sample_sequencer_tick.sv
// Frame-rate divider: one-cycle tick every period+1 enabled cycles, held at 0 while disabled.
// Tick is combinational from the counter; no backpressure.
module tick_divider #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] period,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] count;

  assign tick = enable && (count == period);

  always_ff @(posedge clk) begin
    if (reset || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/sample_sequencer.sv
// Walks the external mux through every channel once per frame tick and presents each sample.
// First sample valid 3+SETTLE_CYCLES after the tick; out_ready low holds the presented sample.
module sample_sequencer
  import sample_sequencer_pkg::*;
#(
  parameter int NUM_CHANNELS  = NUM_CHANNELS_DEFAULT,
  parameter int SAMPLE_BITS   = SAMPLE_BITS_DEFAULT,
  parameter int SETTLE_CYCLES = 2,
  parameter int DIV_WIDTH     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DIV_WIDTH-1:0]   sample_div,
  input  logic [SAMPLE_BITS-1:0] sample_in,
  input  logic                   out_ready,
  input  logic                   clear_overrun,
  output logic [3:0]             ch_sel,
  output logic                   out_valid,
  output logic [3:0]             out_channel,
  output logic [SAMPLE_BITS-1:0] out_data,
  output logic                   frame_start,
  output logic                   frame_done,
  output logic                   overrun
);
  localparam logic [3:0] LAST_CH     = 4'(NUM_CHANNELS - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] ch_idx;
  logic [3:0] settle_cnt;
  logic       tick;
  logic       handshake;

  tick_divider #(.DIV_WIDTH(DIV_WIDTH)) u_tick_divider (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .period (sample_div),
    .tick   (tick)
  );

  // out_valid is only ever high in PRESENT, so ready alone cannot complete a transfer
  assign handshake = out_valid && out_ready;

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt   = SELECT;
          frame_start = 1'b1;
        end
      end
      SELECT:  state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == 4'd0) state_nxt = CAPTURE;
      CAPTURE: state_nxt = PRESENT;
      PRESENT: begin
        if (handshake) begin
          if (ch_idx == LAST_CH) begin
            state_nxt  = IDLE;
            frame_done = 1'b1;
          end else begin
            state_nxt = SELECT;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      frame_start = 1'b0;
      frame_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ch_idx      <= 4'd0;
      settle_cnt  <= 4'd0;
      ch_sel      <= 4'd0;
      out_valid   <= 1'b0;
      out_channel <= 4'd0;
      out_data    <= '0;
      overrun     <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (tick) ch_idx <= 4'd0;
        SELECT: begin
          ch_sel     <= ch_idx;
          settle_cnt <= SETTLE_LOAD;
        end
        SETTLE: if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 1'b1;
        CAPTURE: begin
          out_data    <= sample_in;
          out_channel <= ch_idx;
          out_valid   <= 1'b1;
        end
        PRESENT: begin
          if (handshake) begin
            out_valid <= 1'b0;
            ch_idx    <= (ch_idx == LAST_CH) ? 4'd0 : ch_idx + 4'd1;
          end
        end
        default: ;
      endcase
      // a tick landing mid-frame is dropped; setting wins over a same-cycle clear
      if (tick && state != IDLE) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: frame-level reference model plus vector table and corner sequences.
module tb_sample_sequencer;
  localparam int NCH = 14;
  localparam int S   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] sample_div;
  logic [7:0]  sample_in;
  logic        out_ready;
  logic        clear_overrun;
  logic [3:0]  ch_sel;
  logic        out_valid;
  logic [3:0]  out_channel;
  logic [7:0]  out_data;
  logic        frame_start;
  logic        frame_done;
  logic        overrun;

  logic [7:0]  lut [16];

  always #5 clk = ~clk;
  assign sample_in = lut[ch_sel];

  sample_sequencer #(
    .NUM_CHANNELS(NCH), .SAMPLE_BITS(8), .SETTLE_CYCLES(S), .DIV_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .sample_div(sample_div),
    .sample_in(sample_in), .out_ready(out_ready), .clear_overrun(clear_overrun),
    .ch_sel(ch_sel), .out_valid(out_valid), .out_channel(out_channel),
    .out_data(out_data), .frame_start(frame_start), .frame_done(frame_done),
    .overrun(overrun)
  );

  int errors = 0;
  int checks = 0;

  // frame-level model: busy frame, channel in flight, cycles until its sample appears
  int m_busy, m_valid, m_ch, m_wait, m_ov, m_en_cyc;
  logic seen_fs, seen_fd;

  typedef struct {
    int div;
    int stall_ch;
    int stall_len;
    int exp_len;
    int exp_ov;
  } vec_t;
  vec_t vecs [4];

  int c, ts, td, stalled, ov_end, n, fs_cnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mtick();
    return enable && ((m_en_cyc % (int'(sample_div) + 1)) == int'(sample_div));
  endfunction

  task automatic step();
    bit tk;
    @(negedge clk);
    tk = mtick();
    chk("out_valid", int'(out_valid), m_valid);
    chk("frame_start", int'(frame_start), int'(!reset && m_busy == 0 && tk));
    chk("frame_done", int'(frame_done), int'(!reset && m_valid != 0 && out_ready && m_ch == NCH - 1));
    chk("overrun", int'(overrun), m_ov);
    if (m_valid != 0) begin
      chk("out_channel", int'(out_channel), m_ch);
      chk("out_data", int'(out_data), int'(lut[m_ch]));
      chk("ch_sel", int'(ch_sel), m_ch);
    end
    seen_fs = frame_start;
    seen_fd = frame_done;
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_valid = 0; m_ch = 0; m_ov = 0; m_en_cyc = 0; m_wait = 0;
    end else begin
      if (tk && m_busy != 0) m_ov = 1;
      else if (clear_overrun) m_ov = 0;
      if (m_busy == 0) begin
        if (tk) begin
          m_busy = 1; m_ch = 0; m_wait = S + 2;
        end
      end else if (m_valid != 0) begin
        if (out_ready) begin
          m_valid = 0;
          if (m_ch == NCH - 1) begin
            m_busy = 0; m_ch = 0;
          end else begin
            m_ch++; m_wait = S + 2;
          end
        end
      end else begin
        m_wait--;
        if (m_wait == 0) m_valid = 1;
      end
      m_en_cyc = enable ? m_en_cyc + 1 : 0;
    end
    #1;
  endtask

  task automatic restart(input int div);
    sample_div = 16'(div);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0] = '{div: 100, stall_ch: -1, stall_len: 0, exp_len: 70, exp_ov: 0};
    vecs[1] = '{div: 100, stall_ch: 3,  stall_len: 7, exp_len: 77, exp_ov: 0};
    vecs[2] = '{div: 9,   stall_ch: 5,  stall_len: 3, exp_len: 73, exp_ov: 1};
    vecs[3] = '{div: 0,   stall_ch: -1, stall_len: 0, exp_len: 70, exp_ov: 1};
    for (int k = 0; k < 16; k++) lut[k] = 8'hA5;

    reset = 1'b1; enable = 1'b1; sample_div = 16'd9; out_ready = 1'b1; clear_overrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_busy = 0; m_valid = 0; m_ch = 0; m_ov = 0; m_en_cyc = 0; m_wait = 0;
    chk("rst_ch_sel", int'(ch_sel), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_channel", int'(out_channel), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_overrun", int'(overrun), 0);

    // vector table: first tick position, tick-to-frame_done length, overrun at frame end
    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 16; k++) lut[k] = (v % 2 == 0) ? 8'hA5 : 8'(8'h10 + k);
      enable = 1'b1; out_ready = 1'b1;
      restart(vecs[v].div);
      c = 0; ts = -1; td = -1; stalled = 0; ov_end = -1;
      while (td < 0 && c < 400) begin
        out_ready = !(out_valid && int'(out_channel) == vecs[v].stall_ch && stalled < vecs[v].stall_len);
        if (!out_ready) stalled++;
        step();
        if (seen_fs && ts < 0) ts = c;
        if (seen_fd) begin
          td = c; ov_end = int'(overrun);
        end
        c++;
      end
      chk("vec_first_tick", ts, vecs[v].div);
      chk("vec_frame_len", td - ts, vecs[v].exp_len);
      chk("vec_overrun", ov_end, vecs[v].exp_ov);
    end

    // overrun set by a mid-frame tick, sticky against a same-cycle clear, cleared alone
    out_ready = 1'b0;
    restart(3);
    repeat (9) step();
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_no_restart_valid", int'(out_valid), 1);
    chk("ovr_no_restart_ch", int'(out_channel), 0);
    n = 0;
    while (!mtick() && n < 10) begin
      step(); n++;
    end
    chk("ovr_tick_found", int'(mtick()), 1);
    clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
    chk("ovr_clear_with_tick", int'(overrun), 1);
    clear_overrun = 1'b1; step(); clear_overrun = 1'b0;
    chk("ovr_clear_alone", int'(overrun), 0);

    // reset while channel 6 is being presented
    out_ready = 1'b1;
    restart(200);
    n = 0;
    while (!(out_valid && out_channel == 4'd6) && n < 300) begin
      out_ready = !(out_valid && out_channel == 4'd6);
      step(); n++;
    end
    chk("rst6_reached", int'(out_valid && out_channel == 4'd6), 1);
    reset = 1'b1; step(); reset = 1'b0;
    chk("rst6_no_done", int'(seen_fd), 0);
    chk("rst6_valid", int'(out_valid), 0);
    chk("rst6_channel", int'(out_channel), 0);
    chk("rst6_ch_sel", int'(ch_sel), 0);
    chk("rst6_data", int'(out_data), 0);
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 400) begin
      step(); n++;
    end
    chk("rst6_restart_ch", int'(out_channel), 0);
    chk("rst6_restart_latency", n, 200 + 3 + S);

    // enable dropped mid-frame: frame completes, then no frames until re-enabled
    enable = 1'b1;
    restart(9);
    n = 0;
    while (!(out_valid && out_channel == 4'd2) && n < 100) begin
      step(); n++;
    end
    enable = 1'b0;
    n = 0;
    while (!seen_fd && n < 200) begin
      step(); n++;
    end
    chk("en_frame_done", int'(seen_fd), 1);
    fs_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (seen_fs) fs_cnt++;
    end
    chk("en_no_frame_start", fs_cnt, 0);
    enable = 1'b1;
    n = 0;
    seen_fs = 1'b0;
    while (!seen_fs && n < 30) begin
      step(); n++;
    end
    chk("en_restart_delay", n, 10);

    // randomized traffic against the model
    for (int k = 0; k < 16; k++) lut[k] = 8'($urandom);
    enable = 1'b1;
    restart($urandom_range(0, 60));
    for (int i = 0; i < 2500; i++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      clear_overrun = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) enable = !enable;
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0; clear_overrun = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
